fetch_sequencer: RTL and testbench

//  Owns the program counter and sequences the byte-addressed instruction ROM (4 bytes per fetch, big-endian
//  {mem[a],mem[a+1],mem[a+2],mem[a+3]}). Drives the ROM address, captures the returned word with its PC into
//  a 2-entry fetch buffer and presents it to decode over a valid/ready handshake. Supports redirect (branch/

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer_buffer.sv | 52 +++++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction fetch path: sequencer state, fetch buffer entry
// and the PC increment per fetched word.
package fetch_pkg;

  localparam int PC_STEP  = 4;
  localparam int FETCH_AW = 5;
  localparam int FETCH_IW = 32;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_IW-1:0] instr;
  } fetch_entry_t;

  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/fetch_sequencer_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} words; flush empties it and wins
// over any push or pop in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  entry_t     i_data,
  output entry_t     o_head,
  output logic       o_valid,
  output logic [1:0] o_count
);

  logic       r_head;
  logic [1:0] r_count;
  entry_t     r_mem [2];
  logic       w_wr_idx;

  // With two slots the tail is head+count mod 2; when full it lands on the
  // slot being popped in the same cycle.
  assign w_wr_idx = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_pop)
        r_head <= ~r_head;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[w_wr_idx] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, run/halt control and redirect handling in front of a
// combinational instruction ROM; fetched words are handed to decode via fetch_buffer.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int INSTR_WIDTH = 32,
  parameter int RESET_PC    = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_dout,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   misalign_err,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(PC_STEP);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_misalign;
  logic [CNT_WIDTH-1:0]  r_fetch_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_buf_valid;
  logic [1:0]            w_buf_count;
  entry_t                w_head;
  entry_t                w_tail;

  assign w_pop  = w_buf_valid & out_ready;
  assign w_tail = '{pc: r_pc, instr: rom_dout};

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  // halt seen at an edge already blocks that edge's push, before the state
  // register has caught up.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt)
          w_state_nxt = ST_HALT;
        w_push = ~halt & ~redirect_valid & ((w_buf_count != 2'd2) | w_pop);
      end
      ST_HALT: begin
        if (!halt)
          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RST_PC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid & misaligned(redirect_pc[1:0]);
      if (redirect_valid)
        r_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (w_push)
        r_pc <= r_pc + STEP;
    end
  end

  // A handshake coinciding with a redirect is discarded by the flush, so it is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_fetch_count <= '0;
    else if (w_pop && !redirect_valid && !(&r_fetch_count))
      r_fetch_count <= r_fetch_count + 1'b1;
  end

  fetch_buffer #(
    .entry_t (entry_t)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_tail),
    .o_head  (w_head),
    .o_valid (w_buf_valid),
    .o_count (w_buf_count)
  );

  assign rom_addr     = r_pc;
  assign out_valid    = w_buf_valid;
  assign out_instr    = w_buf_valid ? w_head.instr : '0;
  assign out_pc       = w_buf_valid ? w_head.pc : '0;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle table over reset/stall/redirect/halt/wrap plus
// an in-order scoreboard on every accepted instruction and a counter saturation run.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_pc;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [4:0] sbq[$];
  logic [4:0] sb_next;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [4:0] a);
    logic [7:0] b;
    b = {3'b000, a};
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  assign rom_dout = rom_word(rom_addr);

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      sbq.push_back(sb_next);
      sb_next = sb_next + 5'd4;
    end
  endtask

  task automatic restart_exp(input logic [4:0] start);
    sbq.delete();
    sb_next = start;
    push_exp(16);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word must be the next expected PC, in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got pc %0h want no handshake", out_pc);
      end else begin
        logic [4:0] e;
        e = sbq.pop_front();
        chk("sb_pc", {27'd0, out_pc}, {27'd0, e});
        chk("sb_instr", out_instr, rom_word(e));
      end
    end
  end

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        hlt;
    logic        rdr;
    logic [4:0]  rpc;
    logic        e_v;
    logic [4:0]  e_pc;
    logic [4:0]  e_rom;
    logic [15:0] e_fc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[27];

  initial begin
    // rst rdy hlt rdr rpc    valid pc     rom    fc  mis
    tbl[0]  = '{1, 0, 0, 0, 5'h00, 1, 5'h00, 5'h04, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 5'h00, 1, 5'h00, 5'h08, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 5'h00, 1, 5'h00, 5'h08, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 5'h00, 1, 5'h00, 5'h08, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 5'h00, 1, 5'h00, 5'h08, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 5'h00, 1, 5'h04, 5'h0C, 1, 0};
    tbl[6]  = '{1, 1, 0, 0, 5'h00, 1, 5'h08, 5'h10, 2, 0};
    tbl[7]  = '{1, 1, 0, 0, 5'h00, 1, 5'h0C, 5'h14, 3, 0};
    tbl[8]  = '{1, 1, 0, 1, 5'h10, 0, 5'h00, 5'h10, 3, 0};
    tbl[9]  = '{1, 1, 0, 0, 5'h00, 1, 5'h10, 5'h14, 3, 0};
    tbl[10] = '{1, 1, 0, 0, 5'h00, 1, 5'h14, 5'h18, 4, 0};
    tbl[11] = '{1, 1, 0, 1, 5'h13, 0, 5'h00, 5'h10, 4, 1};
    tbl[12] = '{1, 1, 0, 0, 5'h00, 1, 5'h10, 5'h14, 4, 0};
    tbl[13] = '{1, 1, 1, 0, 5'h00, 0, 5'h00, 5'h14, 5, 0};
    tbl[14] = '{1, 1, 1, 0, 5'h00, 0, 5'h00, 5'h14, 5, 0};
    tbl[15] = '{1, 1, 0, 0, 5'h00, 0, 5'h00, 5'h14, 5, 0};
    tbl[16] = '{1, 1, 0, 0, 5'h00, 1, 5'h14, 5'h18, 5, 0};
    tbl[17] = '{1, 1, 0, 0, 5'h00, 1, 5'h18, 5'h1C, 6, 0};
    tbl[18] = '{1, 1, 0, 0, 5'h00, 1, 5'h1C, 5'h00, 7, 0};
    tbl[19] = '{1, 1, 0, 0, 5'h00, 1, 5'h00, 5'h04, 8, 0};
    tbl[20] = '{1, 1, 1, 1, 5'h08, 0, 5'h00, 5'h08, 8, 0};
    tbl[21] = '{1, 1, 1, 0, 5'h00, 0, 5'h00, 5'h08, 8, 0};
    tbl[22] = '{1, 1, 0, 0, 5'h00, 0, 5'h00, 5'h08, 8, 0};
    tbl[23] = '{1, 1, 0, 0, 5'h00, 1, 5'h08, 5'h0C, 8, 0};
    tbl[24] = '{1, 0, 0, 0, 5'h00, 1, 5'h08, 5'h10, 8, 0};
    tbl[25] = '{0, 0, 0, 0, 5'h00, 0, 5'h00, 5'h00, 0, 0};
    tbl[26] = '{1, 1, 0, 0, 5'h00, 1, 5'h00, 5'h04, 0, 0};

    rst_n          = 1'b0;
    out_ready      = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 5'h00;
    restart_exp(5'h00);
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", {27'd0, out_pc}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_fc", {16'd0, fetch_count}, 32'd0);
    chk("rst_rom", {27'd0, rom_addr}, 32'd0);

    for (int r = 0; r < 27; r++) begin
      rst_n          = tbl[r].rst_n;
      out_ready      = tbl[r].rdy;
      halt           = tbl[r].hlt;
      redirect_valid = tbl[r].rdr;
      redirect_pc    = tbl[r].rpc;
      if (!tbl[r].rst_n)
        restart_exp(5'h00);
      else if (tbl[r].rdr)
        restart_exp({tbl[r].rpc[4:2], 2'b00});
      step();
      chk($sformatf("row%0d_valid", r), {31'd0, out_valid}, {31'd0, tbl[r].e_v});
      chk($sformatf("row%0d_rom", r), {27'd0, rom_addr}, {27'd0, tbl[r].e_rom});
      chk($sformatf("row%0d_fc", r), {16'd0, fetch_count}, {16'd0, tbl[r].e_fc});
      chk($sformatf("row%0d_mis", r), {31'd0, misalign_err}, {31'd0, tbl[r].e_mis});
      if (tbl[r].e_v || !tbl[r].rst_n) begin
        chk($sformatf("row%0d_pc", r), {27'd0, out_pc}, {27'd0, tbl[r].e_pc});
        chk($sformatf("row%0d_instr", r), out_instr,
            tbl[r].e_v ? rom_word(tbl[r].e_pc) : 32'd0);
      end
    end
    redirect_valid = 1'b0;
    halt           = 1'b0;

    // Random back-pressure: order and content checked by the scoreboard.
    push_exp(200);
    for (int i = 0; i < 150; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end

    // Sustained acceptance must not produce bubbles.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
    end

    // Counter saturation from a fresh reset.
    rst_n = 1'b0;
    restart_exp(5'h00);
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 65540; i++) begin
      push_exp(1);
      step();
      if (i == 65535)
        chk("fc_presat", {16'd0, fetch_count}, 32'd65534);
    end
    chk("fc_sat", {16'd0, fetch_count}, 32'h0000FFFF);
    step();
    chk("fc_sat_hold", {16'd0, fetch_count}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
